hold_arbiter: RTL and testbench
===============================

HOLD_ARBITER -- requirements
Module: hold_arbiter

Interface
REQ-001 Parameter MAX_GRANT, default 64, maximum clk cycles one requester may hold the bus per grant (range 2..255).
REQ-002 Parameter TURN, default 2, bus turnaround gap in clk cycles, applied after HLDA rises and after a grant ends (range 1..15).
REQ-003 Parameter MIN_CPU, default 4, minimum clk cycles the CPU owns the bus between two hold periods (range 1..15).
REQ-004 clk  in  1  chipset clock; all state changes on posedge clk.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 REQ  in  2  bus requests, level, held until granted or abandoned; REQ[0]=VGA fetch, REQ[1]=DMA.
REQ-007 DONE  in  2  one-cycle release pulse from the granted requester; same bit mapping as REQ.
REQ-008 HLDA  in  1  CPU hold acknowledge, already synchronised to clk.
REQ-009 HOLD  out  1  hold request to the CPU.
REQ-010 GNT  out  2  one-hot bus grant, same bit mapping as REQ.
REQ-011 CPU_BUS_EN  out  1  high while the CPU owns the address/data buffers.
REQ-012 TIMEOUT  out  1  one-cycle pulse when a grant is revoked by MAX_GRANT.

Function
REQ-013 All outputs SHALL be registered; states: IDLE, WAIT_HLDA, TURN_ON, GRANTED, TURN_OFF, RELEASE.
REQ-014 IDLE: HOLD=0, CPU_BUS_EN=1, GNT=00; a cpu_cnt counts IDLE cycles, saturating at MIN_CPU.
REQ-015 IDLE -> WAIT_HLDA when REQ!=00 and cpu_cnt>=MIN_CPU; HOLD=1 from the first WAIT_HLDA cycle.
REQ-016 WAIT_HLDA -> TURN_ON on the first cycle HLDA=1; CPU_BUS_EN=0 from the first TURN_ON cycle; no timeout on HLDA wait.
REQ-017 TURN_ON lasts exactly TURN cycles, then arbitration: if REQ=00 -> TURN_OFF, else -> GRANTED with winner latched.
REQ-018 Arbitration SHALL be round-robin: one request wins alone; if REQ=11 the bit not granted last wins; last-granted pointer resets to 1 (so VGA wins first contention).
REQ-019 GRANTED: GNT = one-hot winner; grant counter starts at 0 on entry and increments each cycle.
REQ-020 GRANTED exits to TURN_OFF on the cycle after: DONE of winner =1, or REQ of winner =0, or counter = MAX_GRANT-1; DONE/REQ of the non-winner SHALL be ignored.
REQ-021 TIMEOUT=1 for exactly one cycle (first TURN_OFF cycle) only when exit was by counter; if DONE and counter limit coincide, DONE takes priority, TIMEOUT=0.
REQ-022 TURN_OFF: GNT=00, HOLD=1, CPU_BUS_EN=0 for exactly TURN cycles, then RELEASE; no back-to-back grant within one hold period.
REQ-023 RELEASE: HOLD=0; remains until HLDA=0, then IDLE with CPU_BUS_EN=1 and cpu_cnt=0.
REQ-024 Invariants: GNT never 11; GNT!=00 implies HOLD=1, HLDA=1, CPU_BUS_EN=0; CPU_BUS_EN=1 never while GNT!=00.
REQ-025 Counters SHALL be sized for parameter maxima and never wrap.

Reset
REQ-026 RESET=1 SHALL asynchronously force IDLE, HOLD=0, GNT=00, CPU_BUS_EN=1, TIMEOUT=0, counters 0, last-granted=1, cpu_cnt=MIN_CPU.
REQ-027 RESET mid-grant SHALL drop GNT and HOLD immediately; first post-reset request SHALL follow REQ-015 without waiting MIN_CPU.

Verification
REQ-028 Defaults; REQ=01 after reset, HLDA rises 3 cycles after HOLD -> GNT=01 exactly 2 cycles after HLDA seen; DONE[0] at grant cycle 5 -> GNT=00 next cycle, HOLD=0 2 cycles later.
REQ-029 REQ=11 held across 3 hold periods -> grants in order 01,10,01; IDLE gap >=4 cycles between HOLD periods.
REQ-030 REQ=10, never DONE -> GNT=10 for exactly 64 cycles, TIMEOUT pulse 1 cycle, HOLD drops 2 cycles later.
REQ-031 REQ=01 withdrawn during TURN_ON -> no grant, TURN_OFF then RELEASE, TIMEOUT=0.
REQ-032 RESET asserted during GRANTED (GNT=10) -> GNT=00, HOLD=0, CPU_BUS_EN=1 same cycle without clk edge; invariants REQ-024 checked by assertion throughout.
REQ-033 DONE[0] and counter limit in same cycle -> TIMEOUT=0; DONE[1] pulsed while GNT=01 -> ignored.

Source files
------------

// File: rtl/hold_arbiter.sv
// Purpose: arbitrates VGA fetch (REQ[0]) and DMA (REQ[1]) for the CPU bus via HOLD/HLDA, round-robin on contention.
// Latency: all outputs registered; GNT rises TURN cycles after HLDA is seen, and HOLD drops TURN cycles after a grant ends.
// Backpressure: requesters hold REQ until granted; a grant ends on DONE, on REQ withdrawal, or after MAX_GRANT cycles (TIMEOUT).
module hold_arbiter #(
  parameter int MAX_GRANT = 64,
  parameter int TURN      = 2,
  parameter int MIN_CPU   = 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [1:0] REQ,
  input  logic [1:0] DONE,
  input  logic       HLDA,
  output logic       HOLD,
  output logic [1:0] GNT,
  output logic       CPU_BUS_EN,
  output logic       TIMEOUT
);

  typedef enum logic [2:0] {IDLE, WAIT_HLDA, TURN_ON, GRANTED, TURN_OFF, RELEASE} state_t;

  // Terminal values for the shared turnaround/grant counter and the CPU-ownership counter.
  localparam logic [7:0] TURN_LAST  = 8'(TURN - 1);
  localparam logic [7:0] GRANT_LAST = 8'(MAX_GRANT - 1);
  localparam logic [3:0] CPU_MIN    = 4'(MIN_CPU);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;          // turnaround cycles in TURN_ON/TURN_OFF, grant cycles in GRANTED
  logic [3:0] cpu_cnt_q, cpu_cnt_d;  // IDLE cycles since the last hold period, saturating at MIN_CPU
  logic       last_q, last_d;        // index of the requester granted most recently
  logic       win_q, win_d;          // index of the requester owning the current grant
  logic       timeout_d;
  logic       arb_win;

  logic       hold_q, cpu_bus_en_q, timeout_q;
  logic [1:0] gnt_q;

  // Round-robin pick: a lone request wins outright; on contention the one not granted last wins.
  assign arb_win = (REQ == 2'b11) ? ~last_q : REQ[1];

  // Next-state logic and counter updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpu_cnt_d = cpu_cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_cnt_q < CPU_MIN) cpu_cnt_d = cpu_cnt_q + 4'd1;
        if ((REQ != 2'b00) && (cpu_cnt_q >= CPU_MIN)) state_d = WAIT_HLDA;
      end
      WAIT_HLDA: begin
        if (HLDA) begin
          state_d = TURN_ON;
          cnt_d   = 8'd0;
        end
      end
      TURN_ON: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d = 8'd0;
          if (REQ == 2'b00) begin
            state_d = TURN_OFF;
          end else begin
            state_d = GRANTED;
            win_d   = arb_win;
            last_d  = arb_win;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GRANTED: begin
        // Only the winner's DONE/REQ matter; a normal release beats a coincident timeout.
        if (DONE[win_q] || !REQ[win_q]) begin
          state_d = TURN_OFF;
          cnt_d   = 8'd0;
        end else if (cnt_q == GRANT_LAST) begin
          state_d   = TURN_OFF;
          cnt_d     = 8'd0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TURN_OFF: begin
        if (cnt_q == TURN_LAST) begin
          state_d = RELEASE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        if (!HLDA) begin
          state_d   = IDLE;
          cpu_cnt_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the next state so they track it cycle-for-cycle.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      cpu_cnt_q    <= CPU_MIN;
      last_q       <= 1'b1;
      win_q        <= 1'b0;
      hold_q       <= 1'b0;
      gnt_q        <= 2'b00;
      cpu_bus_en_q <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cpu_cnt_q    <= cpu_cnt_d;
      last_q       <= last_d;
      win_q        <= win_d;
      hold_q       <= (state_d == WAIT_HLDA) || (state_d == TURN_ON) ||
                      (state_d == GRANTED) || (state_d == TURN_OFF);
      gnt_q        <= (state_d == GRANTED) ? (win_d ? 2'b10 : 2'b01) : 2'b00;
      cpu_bus_en_q <= (state_d == IDLE) || (state_d == WAIT_HLDA);
      timeout_q    <= timeout_d;
    end
  end

  assign HOLD       = hold_q;
  assign GNT        = gnt_q;
  assign CPU_BUS_EN = cpu_bus_en_q;
  assign TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_hold_arbiter.sv
module tb_hold_arbiter;

  logic       clk = 1'b0;
  logic       RESET;
  logic [1:0] REQ;
  logic [1:0] DONE;
  logic       HLDA;
  logic       HOLD;
  logic [1:0] GNT;
  logic       CPU_BUS_EN;
  logic       TIMEOUT;

  int checks = 0;
  int errors = 0;

  hold_arbiter dut (
    .clk        (clk),
    .RESET      (RESET),
    .REQ        (REQ),
    .DONE       (DONE),
    .HLDA       (HLDA),
    .HOLD       (HOLD),
    .GNT        (GNT),
    .CPU_BUS_EN (CPU_BUS_EN),
    .TIMEOUT    (TIMEOUT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hold(input logic v, input string tag);
    int n = 0;
    while (HOLD !== v && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {7'd0, HOLD}, {7'd0, v});
  endtask

  task automatic wait_gnt(input logic [1:0] exp, input string tag);
    int n = 0;
    while (GNT === 2'b00 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {6'd0, GNT}, {6'd0, exp});
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ   = 2'b00;
    DONE  = 2'b00;
    HLDA  = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  // One complete hold period with REQ held at 11: optional IDLE-gap check, grant order, release.
  task automatic rr_period(input logic [1:0] exp, input bit check_gap, input string tag);
    int gap = 0;
    tick();
    while (HOLD !== 1'b1 && gap < 50) begin
      gap++;
      tick();
    end
    chk({tag, "_hold"}, {7'd0, HOLD}, 8'd1);
    if (check_gap) chk({tag, "_gap_ge4"}, {7'd0, (gap >= 4)}, 8'd1);
    HLDA = 1'b1;
    wait_gnt(exp, {tag, "_gnt"});
    DONE = exp;
    tick();
    DONE = 2'b00;
    chk({tag, "_gnt_off"}, {6'd0, GNT}, 8'd0);
    wait_hold(1'b0, {tag, "_hold_off"});
    HLDA = 1'b0;
    tick();
  endtask

  // Bus invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (RESET === 1'b0) begin
      checks++;
      assert ((GNT !== 2'b11) &&
              ((GNT === 2'b00) || (HOLD === 1'b1 && HLDA === 1'b1 && CPU_BUS_EN === 1'b0))) else begin
        errors++;
        $error("FAIL invariant GNT=%b HOLD=%b HLDA=%b CPU_BUS_EN=%b", GNT, HOLD, HLDA, CPU_BUS_EN);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    RESET = 1'b1;
    REQ   = 2'b00;
    DONE  = 2'b00;
    HLDA  = 1'b0;
    tick();
    tick();
    chk("rst_hold", {7'd0, HOLD}, 8'd0);
    chk("rst_gnt", {6'd0, GNT}, 8'd0);
    chk("rst_cpu_en", {7'd0, CPU_BUS_EN}, 8'd1);
    chk("rst_timeout", {7'd0, TIMEOUT}, 8'd0);
    RESET = 1'b0;

    // Single VGA grant: HLDA 3 cycles after HOLD, grant 2 cycles after HLDA, DONE in grant cycle 5.
    REQ = 2'b01;
    tick();
    chk("t1_hold_up", {7'd0, HOLD}, 8'd1);
    chk("t1_cpu_en_wait", {7'd0, CPU_BUS_EN}, 8'd1);
    tick();
    tick();
    tick();
    HLDA = 1'b1;
    tick();
    chk("t1_turn_on_gnt", {6'd0, GNT}, 8'd0);
    chk("t1_turn_on_cpu_en", {7'd0, CPU_BUS_EN}, 8'd0);
    tick();
    chk("t1_turn_on2_gnt", {6'd0, GNT}, 8'd0);
    tick();
    chk("t1_gnt_c1", {6'd0, GNT}, 8'h01);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("t1_gnt_held", {6'd0, GNT}, 8'h01);
    end
    DONE = 2'b01;
    tick();
    DONE = 2'b00;
    REQ  = 2'b00;
    chk("t1_gnt_drop", {6'd0, GNT}, 8'd0);
    chk("t1_no_timeout", {7'd0, TIMEOUT}, 8'd0);
    tick();
    chk("t1_hold_turn_off", {7'd0, HOLD}, 8'd1);
    tick();
    chk("t1_hold_release", {7'd0, HOLD}, 8'd0);
    HLDA = 1'b0;
    tick();
    chk("t1_cpu_en_back", {7'd0, CPU_BUS_EN}, 8'd1);

    // Round-robin over three hold periods with both requests held.
    do_reset();
    REQ = 2'b11;
    rr_period(2'b01, 1'b0, "rr1");
    rr_period(2'b10, 1'b1, "rr2");
    rr_period(2'b01, 1'b1, "rr3");
    REQ = 2'b00;

    // DMA never releases: grant revoked after MAX_GRANT cycles.
    REQ = 2'b10;
    wait_hold(1'b1, "t3_hold");
    HLDA = 1'b1;
    wait_gnt(2'b10, "t3_gnt");
    len = 1;
    tick();
    while (GNT === 2'b10 && len < 300) begin
      len++;
      tick();
    end
    chk("t3_grant_len", 8'(len), 8'd64);
    chk("t3_timeout", {7'd0, TIMEOUT}, 8'd1);
    tick();
    chk("t3_timeout_1cyc", {7'd0, TIMEOUT}, 8'd0);
    chk("t3_hold_still", {7'd0, HOLD}, 8'd1);
    tick();
    chk("t3_hold_drop", {7'd0, HOLD}, 8'd0);
    REQ  = 2'b00;
    HLDA = 1'b0;
    tick();

    // Request withdrawn during TURN_ON: no grant, no timeout, hold released.
    REQ = 2'b01;
    wait_hold(1'b1, "t4_hold");
    HLDA = 1'b1;
    tick();
    REQ = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_no_gnt", {6'd0, GNT}, 8'd0);
      chk("t4_no_timeout", {7'd0, TIMEOUT}, 8'd0);
    end
    chk("t4_hold_drop", {7'd0, HOLD}, 8'd0);
    HLDA = 1'b0;
    tick();
    chk("t4_cpu_en", {7'd0, CPU_BUS_EN}, 8'd1);

    // Foreign DONE ignored; DONE coinciding with the grant limit suppresses TIMEOUT.
    REQ = 2'b01;
    wait_hold(1'b1, "t5_hold");
    HLDA = 1'b1;
    wait_gnt(2'b01, "t5_gnt");
    tick();
    DONE = 2'b10;
    tick();
    DONE = 2'b00;
    chk("t5_foreign_done", {6'd0, GNT}, 8'h01);
    for (int k = 3; k < 64; k++) tick();
    chk("t5_gnt_c64", {6'd0, GNT}, 8'h01);
    DONE = 2'b01;
    tick();
    DONE = 2'b00;
    chk("t5_gnt_drop", {6'd0, GNT}, 8'd0);
    chk("t5_no_timeout", {7'd0, TIMEOUT}, 8'd0);
    wait_hold(1'b0, "t5_hold_off");
    REQ  = 2'b00;
    HLDA = 1'b0;
    tick();

    // Asynchronous reset during a DMA grant, then an immediate new request.
    REQ = 2'b10;
    wait_hold(1'b1, "t6_hold");
    HLDA = 1'b1;
    wait_gnt(2'b10, "t6_gnt");
    tick();
    #2;
    RESET = 1'b1;
    HLDA  = 1'b0;
    #1;
    chk("t6_async_gnt", {6'd0, GNT}, 8'd0);
    chk("t6_async_hold", {7'd0, HOLD}, 8'd0);
    chk("t6_async_cpu_en", {7'd0, CPU_BUS_EN}, 8'd1);
    chk("t6_async_timeout", {7'd0, TIMEOUT}, 8'd0);
    tick();
    RESET = 1'b0;
    tick();
    chk("t6_post_rst_hold", {7'd0, HOLD}, 8'd1);
    REQ = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
